// File: rtl/uart_rcvr_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rcvr_cfg
// Description : Runtime-configurable UART receiver (5-8 data bits, optional
//               parity, 1/2 stop bits) feeding a status-tagged FWFT FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rcvr_cfg #(
    parameter int W       = 8,
    parameter int ADDR_W  = 4,
    parameter int SB_TICK = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_tick,
    input  logic              rx,
    input  logic [1:0]        cfg_dbits,
    input  logic              cfg_par_en,
    input  logic              cfg_par_odd,
    input  logic              cfg_stop2,
    input  logic              rd_uart,
    input  logic              clr_overrun,
    output logic [W-1:0]      r_data,
    output logic              r_perr,
    output logic              r_ferr,
    output logic              rx_empty,
    output logic              rx_full,
    output logic [ADDR_W:0]   rx_level,
    output logic              overrun
);

    localparam int              c_tw        = $clog2(SB_TICK);
    localparam logic [c_tw-1:0] c_tick_last = c_tw'(SB_TICK - 1);
    localparam logic [c_tw-1:0] c_tick_mid  = c_tw'(SB_TICK / 2 - 1);
    localparam int              c_depth     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_full_lvl  = (ADDR_W + 1)'(c_depth);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t          r_state,    w_state_nxt;
    logic [c_tw-1:0] r_tick,     w_tick_nxt;
    logic [2:0]      r_bit,      w_bit_nxt;
    logic [W-1:0]    r_shift,    w_shift_nxt;
    logic [1:0]      r_dbits,    w_dbits_nxt;
    logic            r_par_en,   w_par_en_nxt;
    logic            r_par_odd,  w_par_odd_nxt;
    logic            r_stop2,    w_stop2_nxt;
    logic            r_perr_acc, w_perr_nxt;
    logic            r_ferr_acc, w_ferr_nxt;
    logic            w_done;
    logic [2:0]      w_last_bit;
    logic            w_ferr_sample;

    assign w_last_bit = {1'b0, r_dbits} + 3'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_dbits    <= 2'b11;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_stop2    <= 1'b0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick     <= w_tick_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_dbits    <= w_dbits_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_odd  <= w_par_odd_nxt;
            r_stop2    <= w_stop2_nxt;
            r_perr_acc <= w_perr_nxt;
            r_ferr_acc <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_dbits_nxt   = r_dbits;
        w_par_en_nxt  = r_par_en;
        w_par_odd_nxt = r_par_odd;
        w_stop2_nxt   = r_stop2;
        w_perr_nxt    = r_perr_acc;
        w_ferr_nxt    = r_ferr_acc;
        w_done        = 1'b0;
        w_ferr_sample = r_ferr_acc | ~r_rx_sync;

        case (r_state)
            S_IDLE: begin
                // Frame format is frozen at the start edge
                if (!r_rx_sync) begin
                    w_state_nxt   = S_START;
                    w_tick_nxt    = '0;
                    w_bit_nxt     = '0;
                    w_shift_nxt   = '0;
                    w_perr_nxt    = 1'b0;
                    w_ferr_nxt    = 1'b0;
                    w_dbits_nxt   = cfg_dbits;
                    w_par_en_nxt  = cfg_par_en;
                    w_par_odd_nxt = cfg_par_odd;
                    w_stop2_nxt   = cfg_stop2;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (r_tick == c_tick_mid) begin
                        w_tick_nxt = '0;
                        if (r_rx_sync) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (r_tick == c_tick_last) begin
                        w_tick_nxt         = '0;
                        w_shift_nxt[r_bit] = r_rx_sync;
                        if (r_bit == w_last_bit) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            w_bit_nxt = r_bit + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (s_tick) begin
                    if (r_tick == c_tick_last) begin
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_perr_nxt  = ((^r_shift) ^ r_rx_sync) != r_par_odd;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (s_tick) begin
                    if (r_tick == c_tick_last) begin
                        w_tick_nxt = '0;
                        w_ferr_nxt = w_ferr_sample;
                        if (r_stop2 && (r_bit == 3'd0)) begin
                            w_bit_nxt = 3'd1;
                        end else begin
                            w_done      = 1'b1;
                            w_state_nxt = w_ferr_sample ? S_WAIT_HIGH : S_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) produces one entry, then idles here
                if (r_rx_sync) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status-tagged FWFT FIFO
    // ------------------------------------------------------------------
    logic [W+1:0]    r_mem [c_depth];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_overrun;
    logic              w_full;
    logic              w_empty;
    logic              w_wr;
    logic              w_rd;
    logic              w_drop;
    logic [W+1:0]      w_head;

    assign w_full  = (r_level == c_full_lvl);
    assign w_empty = (r_level == '0);
    assign w_rd    = rd_uart & ~w_empty;
    // A coincident pop frees the slot, so a full FIFO still accepts the write
    assign w_wr    = w_done & (~w_full | rd_uart);
    assign w_drop  = w_done & w_full & ~rd_uart;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_ferr_sample, r_perr_acc, r_shift};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign w_head   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign r_data   = w_head[W-1:0];
    assign r_perr   = w_head[W];
    assign r_ferr   = w_head[W+1];
    assign rx_empty = w_empty;
    assign rx_full  = w_full;
    assign rx_level = r_level;
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rcvr_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rcvr_cfg
// Description : Directed self-checking bench for uart_rcvr_cfg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rcvr_cfg;

    localparam int c_bit_clks = 32;   // s_tick every 2 clk, 16 ticks per bit

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       rx;
    logic [1:0] cfg_dbits;
    logic       cfg_par_en;
    logic       cfg_par_odd;
    logic       cfg_stop2;
    logic       rd_uart;
    logic       clr_overrun;
    logic [7:0] r_data;
    logic       r_perr;
    logic       r_ferr;
    logic       rx_empty;
    logic       rx_full;
    logic [4:0] rx_level;
    logic       overrun;

    int vectors;
    int miscompares;

    uart_rcvr_cfg #(.W(8), .ADDR_W(4), .SB_TICK(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .rx          (rx),
        .cfg_dbits   (cfg_dbits),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .cfg_stop2   (cfg_stop2),
        .rd_uart     (rd_uart),
        .clr_overrun (clr_overrun),
        .r_data      (r_data),
        .r_perr      (r_perr),
        .r_ferr      (r_ferr),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .rx_level    (rx_level),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial s_tick = 1'b0;
    always @(posedge clk) s_tick <= ~s_tick;

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input bit pbit, input bit s1, input bit s2, input int nstop,
                              input int chg_at, input logic [1:0] chg_val);
        logic [11:0] bits;
        int n;
        bits = '0;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nbits; i++) begin bits[n] = d[i]; n++; end
        if (par_en) begin bits[n] = pbit; n++; end
        bits[n] = s1; n++;
        if (nstop == 2) begin bits[n] = s2; n++; end
        for (int i = 0; i < n; i++) begin
            if (i == chg_at) cfg_dbits = chg_val;
            rx = bits[i];
            repeat (c_bit_clks) @(posedge clk);
        end
        rx = 1'b1;
        repeat (2 * c_bit_clks) @(posedge clk);
    endtask

    task automatic pop();
        @(negedge clk) rd_uart = 1'b1;
        @(negedge clk) rd_uart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", rx_empty); end
        vectors++; if (rx_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", rx_full); end
        vectors++; if (rx_level !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", rx_level); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        vectors++; if ({r_ferr, r_perr, r_data} !== 10'h000) begin miscompares++; $display("FAIL reset_head: got %h want 000", {r_ferr, r_perr, r_data}); end
        reset = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_8n1();
        bit seen;
        seen = 1'b0;
        cfg_dbits = 2'b11; cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 2'b00);
            begin
                for (int i = 0; i < 600; i++) begin
                    @(negedge clk);
                    if (dut.w_done === 1'b1) begin seen = 1'b1; break; end
                end
                if (seen) begin
                    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL 8n1_empty_at_done: got %b want 1", rx_empty); end
                    @(negedge clk);
                    vectors++; if (rx_empty !== 1'b0) begin miscompares++; $display("FAIL 8n1_empty_after_done: got %b want 0", rx_empty); end
                    vectors++; if (rx_level !== 5'd1) begin miscompares++; $display("FAIL 8n1_level: got %0d want 1", rx_level); end
                end
            end
        join
        vectors++; if (!seen) begin miscompares++; $display("FAIL 8n1_done_timeout: got none want done pulse"); end
        vectors++; if (r_data !== 8'hA5) begin miscompares++; $display("FAIL 8n1_data: got %h want a5", r_data); end
        vectors++; if ({r_ferr, r_perr} !== 2'b00) begin miscompares++; $display("FAIL 8n1_flags: got %b want 00", {r_ferr, r_perr}); end
        pop();
        @(negedge clk);
        vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL 8n1_pop_empty: got %b want 1", rx_empty); end
    endtask

    task automatic test_parity();
        // 0x41 (7 bits) has two ones: even wants pbit 0, odd wants pbit 1
        bit exp_perr [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        bit pbits    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        bit odds     [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        cfg_dbits = 2'b10; cfg_par_en = 1'b1; cfg_stop2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cfg_par_odd = odds[k];
            send_frame(8'h41, 7, 1'b1, pbits[k], 1'b1, 1'b1, 1, -1, 2'b00);
            vectors++; if (r_data !== 8'h41) begin miscompares++; $display("FAIL par_data[%0d]: got %h want 41", k, r_data); end
            vectors++; if (r_perr !== exp_perr[k]) begin miscompares++; $display("FAIL par_perr[%0d]: got %b want %b", k, r_perr, exp_perr[k]); end
            vectors++; if (r_ferr !== 1'b0) begin miscompares++; $display("FAIL par_ferr[%0d]: got %b want 0", k, r_ferr); end
            pop();
        end
        cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
    endtask

    task automatic test_break();
        cfg_dbits = 2'b00; cfg_stop2 = 1'b1;
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 2, -1, 2'b00);
        vectors++; if (r_data !== 8'h1F) begin miscompares++; $display("FAIL ferr_data: got %h want 1f", r_data); end
        vectors++; if ({r_ferr, r_perr} !== 2'b10) begin miscompares++; $display("FAIL ferr_flags: got %b want 10", {r_ferr, r_perr}); end
        pop();
        rx = 1'b0;
        repeat (3 * 8 * c_bit_clks) @(posedge clk);
        rx = 1'b1;
        repeat (2 * c_bit_clks) @(posedge clk);
        @(negedge clk);
        vectors++; if (rx_level !== 5'd1) begin miscompares++; $display("FAIL break_level: got %0d want 1", rx_level); end
        vectors++; if ({r_ferr, r_perr, r_data} !== 10'h200) begin miscompares++; $display("FAIL break_entry: got %h want 200", {r_ferr, r_perr, r_data}); end
        pop();
        cfg_dbits = 2'b11; cfg_stop2 = 1'b0;
    endtask

    task automatic test_glitch_cfg();
        rx = 1'b0;
        repeat (8) @(posedge clk);
        rx = 1'b1;
        repeat (2 * c_bit_clks) @(posedge clk);
        @(negedge clk);
        vectors++; if (rx_level !== 5'd0) begin miscompares++; $display("FAIL glitch_level: got %0d want 0", rx_level); end
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 3, 2'b00);
        vectors++; if (rx_level !== 5'd1) begin miscompares++; $display("FAIL cfgchg_level: got %0d want 1", rx_level); end
        vectors++; if ({r_ferr, r_perr, r_data} !== 10'h0C3) begin miscompares++; $display("FAIL cfgchg_entry: got %h want 0c3", {r_ferr, r_perr, r_data}); end
        pop();
        cfg_dbits = 2'b11;
    endtask

    task automatic test_overflow();
        bit seen;
        for (int k = 0; k < 17; k++) begin
            send_frame(8'(k), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 2'b00);
        end
        vectors++; if (rx_level !== 5'd16) begin miscompares++; $display("FAIL ovf_level: got %0d want 16", rx_level); end
        vectors++; if (rx_full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b want 1", rx_full); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovf_overrun: got %b want 1", overrun); end
        vectors++; if (r_data !== 8'h00) begin miscompares++; $display("FAIL ovf_head: got %h want 00", r_data); end
        seen = 1'b0;
        fork
            send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 2'b00);
            begin
                for (int i = 0; i < 600; i++) begin
                    @(negedge clk);
                    if (dut.w_done === 1'b1) begin seen = 1'b1; rd_uart = 1'b1; break; end
                end
                @(negedge clk);
                rd_uart = 1'b0;
            end
        join
        vectors++; if (!seen) begin miscompares++; $display("FAIL ovf_done_timeout: got none want done pulse"); end
        vectors++; if (rx_level !== 5'd16) begin miscompares++; $display("FAIL ovf_coinc_level: got %0d want 16", rx_level); end
        @(negedge clk) clr_overrun = 1'b1;
        @(negedge clk) clr_overrun = 1'b0;
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b want 0", overrun); end
        // Expected queue: 1..15 then 0x11 (0x10 was dropped)
        for (int k = 1; k <= 16; k++) begin
            logic [7:0] exp_d;
            exp_d = (k == 16) ? 8'h11 : 8'(k);
            vectors++; if (r_data !== exp_d) begin miscompares++; $display("FAIL ovf_entry[%0d]: got %h want %h", k, r_data, exp_d); end
            pop();
        end
        vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL ovf_drained: got %b want 1", rx_empty); end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h21, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 2'b00);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 2'b00);
        send_frame(8'h23, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 2'b00);
        vectors++; if (rx_level !== 5'd3) begin miscompares++; $display("FAIL rst_pre_level: got %0d want 3", rx_level); end
        rx = 1'b0;
        repeat (c_bit_clks) @(posedge clk);
        rx = 1'b1;
        repeat (2 * c_bit_clks) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL rst_mid_empty: got %b want 1", rx_empty); end
        vectors++; if (rx_level !== 5'd0) begin miscompares++; $display("FAIL rst_mid_level: got %0d want 0", rx_level); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_mid_overrun: got %b want 0", overrun); end
        repeat (4 * c_bit_clks) @(posedge clk);
        @(negedge clk);
        vectors++; if (rx_level !== 5'd0) begin miscompares++; $display("FAIL rst_mid_no_stale: got %0d want 0", rx_level); end
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 2'b00);
        vectors++; if (rx_level !== 5'd1) begin miscompares++; $display("FAIL rst_next_level: got %0d want 1", rx_level); end
        vectors++; if ({r_ferr, r_perr, r_data} !== 10'h05A) begin miscompares++; $display("FAIL rst_next_entry: got %h want 05a", {r_ferr, r_perr, r_data}); end
        pop();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        rx = 1'b1;
        rd_uart = 1'b0;
        clr_overrun = 1'b0;
        cfg_dbits = 2'b11;
        cfg_par_en = 1'b0;
        cfg_par_odd = 1'b0;
        cfg_stop2 = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_break();
        test_glitch_cfg();
        test_overflow();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
